// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // Request side: valid/ready, transfer on a rising edge where both are high;
    // the master may change op/addr/wdata freely once the request is taken.
    // Response side: resp_valid is a one-cycle strobe with no back-pressure.
    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle big-endian data memory: takes one MIPS load/store, waits LATENCY
// cycles, then commits the store or returns extended load data for one cycle.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus,
    output logic [1:0]      o_dbg_state
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic [1:0] SZ_B     = 2'd0;
    localparam logic [1:0] SZ_H     = 2'd1;
    localparam logic [1:0] SZ_W     = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic [5:0]          r_op;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [31:0]         r_mem [DEPTH];

    logic                w_ready;
    logic                w_resp_valid;
    logic                w_accept;
    logic                w_access;
    logic                w_unused_addr;

    logic                w_op_ok;
    logic                w_is_load;
    logic                w_signed;
    logic [1:0]          w_size;
    logic                w_misalign;
    logic                w_err;
    logic                w_we;
    logic [ADDR_W-1:0]   w_idx;
    logic [1:0]          w_off;
    logic [31:0]         w_rd_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_val;
    logic [31:0]         w_wr_word;

    // Upper address bits only select aliases of the same word.
    assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_resp_valid = 1'b0;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp_valid = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_op_ok   = 1'b1;
        w_is_load = 1'b0;
        w_signed  = 1'b0;
        w_size    = SZ_W;
        case (r_op)
            6'h20: begin w_is_load = 1'b1; w_signed = 1'b1; w_size = SZ_B; end
            6'h21: begin w_is_load = 1'b1; w_signed = 1'b1; w_size = SZ_H; end
            6'h23: begin w_is_load = 1'b1; w_size = SZ_W; end
            6'h24: begin w_is_load = 1'b1; w_size = SZ_B; end
            6'h25: begin w_is_load = 1'b1; w_size = SZ_H; end
            6'h28: w_size = SZ_B;
            6'h29: w_size = SZ_H;
            6'h2B: w_size = SZ_W;
            default: w_op_ok = 1'b0;
        endcase
    end

    assign w_idx      = r_addr[ADDR_W+1:2];
    assign w_off      = r_addr[1:0];
    assign w_rd_word  = r_mem[w_idx];
    assign w_misalign = ((w_size == SZ_H) && w_off[0]) ||
                        ((w_size == SZ_W) && (w_off != 2'd0));
    assign w_err      = !w_op_ok || w_misalign;
    assign w_we       = w_access && !w_is_load && !w_err && !reset;

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        w_byte = w_rd_word[7:0];
        case (w_off)
            2'd0: w_byte = w_rd_word[31:24];
            2'd1: w_byte = w_rd_word[23:16];
            2'd2: w_byte = w_rd_word[15:8];
            default: w_byte = w_rd_word[7:0];
        endcase
        w_half = w_off[1] ? w_rd_word[15:0] : w_rd_word[31:16];
        case (w_size)
            SZ_B:    w_load_val = {{24{w_signed & w_byte[7]}}, w_byte};
            SZ_H:    w_load_val = {{16{w_signed & w_half[15]}}, w_half};
            default: w_load_val = w_rd_word;
        endcase
    end

    always_comb begin
        w_wr_word = w_rd_word;
        case (w_size)
            SZ_B: begin
                case (w_off)
                    2'd0: w_wr_word[31:24] = r_wdata[7:0];
                    2'd1: w_wr_word[23:16] = r_wdata[7:0];
                    2'd2: w_wr_word[15:8]  = r_wdata[7:0];
                    default: w_wr_word[7:0] = r_wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (w_off[1]) begin
                    w_wr_word[15:0] = r_wdata[15:0];
                end else begin
                    w_wr_word[31:16] = r_wdata[15:0];
                end
            end
            default: w_wr_word = r_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_op    <= 6'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= bus.req_op;
                r_addr  <= bus.req_addr[ADDR_W+1:0];
                r_wdata <= bus.req_wdata;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_rdata <= (w_is_load && !w_err) ? w_load_val : 32'd0;
                r_err   <= w_err;
            end
        end
    end

    // Array is deliberately left out of reset; a reset at the access edge blocks the write.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign o_dbg_state    = r_state;
endmodule
